// File: rtl/herald_host_seq.sv
// herald_host_seq -- upstream transaction sequencer for the Herald CORDIC
// command wrapper. Takes one parallel request (opcode, arg1, arg2), walks the
// wrapper's byte-wide command bus through SET_OP, LOAD1/LOAD2, START, a fixed
// wait, and four READ/NOP pairs, then presents the assembled 32-bit result.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/req_ready request handshake; req_opcode, req_arg1, req_arg2
//   cmd_out             registered command bus: [7:5] cmd, [4:2] data, [1:0] idx
//   rd_byte             wrapper byte output, sampled in the capture cycle
//   rsp_valid/rsp_ready response handshake; rsp_data (byte 0 in [7:0])
//   perf_cycles, perf_txn  only when HERALD_SEQ_PERF_EN is defined
//
// Optional feature macro: HERALD_SEQ_PERF_EN adds the accept-to-response cycle
// counter and the completed-transaction counter.
module herald_host_seq #(
  parameter int WAIT_CYCLES = 40,
  parameter int WAIT_W      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_opcode,
  input  logic [31:0] req_arg1,
  input  logic [31:0] req_arg2,
  output logic [7:0]  cmd_out,
  input  logic [7:0]  rd_byte,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data
`ifdef HERALD_SEQ_PERF_EN
  ,
  output logic [15:0] perf_cycles,
  output logic [15:0] perf_txn
`endif
);

  typedef enum logic [3:0] {
    S_IDLE, S_SETOP, S_LOAD1, S_LOAD2, S_START,
    S_WAIT, S_RD_ISSUE, S_RD_CAP, S_RESP
  } state_t;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;

  state_t            state, state_nxt;
  logic [1:0]        idx, idx_nxt;
  logic [WAIT_W-1:0] wcnt, wcnt_nxt;
  logic [2:0]        op, op_nxt;
  logic [31:0]       arg1, arg1_nxt, arg2, arg2_nxt;
  logic              accept;

  assign accept   = req_valid && req_ready;
  assign op_nxt   = accept ? req_opcode : op;
  assign arg1_nxt = accept ? req_arg1   : arg1;
  assign arg2_nxt = accept ? req_arg2   : arg2;

  // Command driven while sitting in state s. cmd_out is loaded from the next
  // state so the command appears in the same cycle as the state itself.
  function automatic logic [7:0] cmd_for(state_t s, logic [1:0] i, logic [2:0] o,
                                         logic [31:0] x1, logic [31:0] x2);
    logic [7:0] c;
    c = 8'h00;
    case (s)
      S_SETOP:    c = {3'd1, 2'b00, o};
      S_LOAD1:    c = {3'd2, x1[{i, 3'b000} +: 3], i};
      S_LOAD2:    c = {3'd3, x2[{i, 3'b000} +: 3], i};
      S_START:    c = 8'h80;
      S_RD_ISSUE: c = {3'd5, 3'd0, i};
      default:    c = 8'h00;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wcnt_nxt  = wcnt;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_SETOP;
      S_SETOP: begin
        state_nxt = S_LOAD1;
        idx_nxt   = 2'd0;
      end
      S_LOAD1: begin
        if (idx == 2'd3) begin
          idx_nxt = 2'd0;
          // sin_cos takes a single argument, so the second load is skipped
          state_nxt = (op != 3'd0) ? S_LOAD2 : S_START;
        end else idx_nxt = idx + 2'd1;
      end
      S_LOAD2: begin
        if (idx == 2'd3) begin
          idx_nxt   = 2'd0;
          state_nxt = S_START;
        end else idx_nxt = idx + 2'd1;
      end
      S_START: begin
        wcnt_nxt  = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt != WAIT_MAX) wcnt_nxt = wcnt + 1'b1;
        if (wcnt == WAIT_LAST) begin
          state_nxt = S_RD_ISSUE;
          idx_nxt   = 2'd0;
        end
      end
      S_RD_ISSUE: state_nxt = S_RD_CAP;
      S_RD_CAP: begin
        // the NOP in this cycle returns the wrapper to idle between reads
        if (idx == 2'd3) state_nxt = S_RESP;
        else begin
          idx_nxt   = idx + 2'd1;
          state_nxt = S_RD_ISSUE;
        end
      end
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx       <= '0;
      wcnt      <= '0;
      op        <= '0;
      arg1      <= '0;
      arg2      <= '0;
      cmd_out   <= 8'h00;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      idx       <= idx_nxt;
      wcnt      <= wcnt_nxt;
      op        <= op_nxt;
      arg1      <= arg1_nxt;
      arg2      <= arg2_nxt;
      cmd_out   <= cmd_for(state_nxt, idx_nxt, op_nxt, arg1_nxt, arg2_nxt);
      // registered ready keeps the first cycle after reset release closed
      req_ready <= (state_nxt == S_IDLE);
      rsp_valid <= (state_nxt == S_RESP);
      if (state == S_RD_CAP) rsp_data[{idx, 3'b000} +: 8] <= rd_byte;
    end
  end

`ifdef HERALD_SEQ_PERF_EN
  // perf_cycles counts the accept cycle too, so it equals the accept-to-valid
  // latency and freezes in RESP until the next accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_txn    <= '0;
    end else begin
      if (accept) perf_cycles <= 16'd1;
      else if (state != S_IDLE && state != S_RESP) perf_cycles <= perf_cycles + 16'd1;
      if (rsp_valid && rsp_ready) perf_txn <= perf_txn + 16'd1;
    end
  end
`else
  // no performance counters in this build
`endif

endmodule

// File: tb/tb_herald_host_seq.sv
// Scoreboard bench for herald_host_seq: stimulus pushes the expected command
// stream, result and latency; a negedge monitor pops and compares them.
module tb_herald_host_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_opcode;
  logic [31:0] req_arg1, req_arg2;
  logic [7:0]  cmd_out;
  logic [7:0]  rd_byte;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
`ifdef HERALD_SEQ_PERF_EN
  logic [15:0] perf_cycles, perf_txn;
`endif

  herald_host_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_arg1(req_arg1), .req_arg2(req_arg2),
    .cmd_out(cmd_out), .rd_byte(rd_byte),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
`ifdef HERALD_SEQ_PERF_EN
    , .perf_cycles(perf_cycles), .perf_txn(perf_txn)
`endif
  );

  always #5 clk = ~clk;

  // wrapper model: a READ idx puts the requested byte on rd_byte next cycle
  logic [31:0] rd_model = 32'h0;
  always @(posedge clk) begin
    if (cmd_out[7:5] == 3'd5) rd_byte <= rd_model[{cmd_out[1:0], 3'b000} +: 8];
  end

  logic [7:0]  cmd_q[$];
  logic [31:0] rsp_q[$];
  int          lat_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor state
  bit          active = 0;
  bit          seen = 0;
  bit          hs_next = 0;
  int          cyc = 0;
  int          rst_cyc = 0;
  int          txn_cnt = 0;
  logic [31:0] cur_data = 0;
  int          cur_lat = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      rst_cyc++;
      if (rst_cyc >= 2) begin
        chk("rst_cmd_out", 32'(cmd_out), 32'h00);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
      end
      cmd_q.delete();
      active = 0; hs_next = 0; txn_cnt = 0;
    end else begin
      if (rst_cyc >= 2) chk("release_req_ready", 32'(req_ready), 32'h0);
      rst_cyc = 0;
      if (hs_next) begin
        hs_next = 0;
        chk("post_rsp_req_ready", 32'(req_ready), 32'h1);
`ifdef HERALD_SEQ_PERF_EN
        chk("perf_cycles", 32'(perf_cycles), 32'(cur_lat));
        chk("perf_txn", 32'(perf_txn), 32'(txn_cnt));
`endif
      end
      if (active) begin
        cyc++;
        if (cmd_q.size() > 0) chk("cmd_out", 32'(cmd_out), 32'(cmd_q.pop_front()));
        if (rsp_valid) begin
          if (!seen) begin
            seen = 1;
            chk("latency", 32'(cyc), 32'(cur_lat));
          end
          chk("rsp_data", rsp_data, cur_data);
          chk("busy_req_ready", 32'(req_ready), 32'h0);
          if (rsp_ready) begin
            active = 0; hs_next = 1; txn_cnt++;
          end
        end
      end else begin
        chk("idle_cmd_out", 32'(cmd_out), 32'h00);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'h0);
        if (req_valid && req_ready) begin
          active = 1; cyc = 0; seen = 0;
          if (rsp_q.size() > 0) begin
            cur_data = rsp_q.pop_front();
            cur_lat  = lat_q.pop_front();
          end else begin
            cur_data = 32'h0;
            cur_lat  = 0; // aborted transaction: any response is wrong
          end
        end
      end
    end
  end

  task automatic push_cmds(input logic [2:0] op, input logic [31:0] a1, input logic [31:0] a2);
    logic [1:0] ii;
    cmd_q.push_back({3'd1, 2'b00, op});
    for (int i = 0; i < 4; i++) begin
      ii = 2'(i);
      cmd_q.push_back({3'd2, a1[8*i +: 3], ii});
    end
    if (op != 3'd0)
      for (int i = 0; i < 4; i++) begin
        ii = 2'(i);
        cmd_q.push_back({3'd3, a2[8*i +: 3], ii});
      end
    cmd_q.push_back(8'h80);
    for (int i = 0; i < 40; i++) cmd_q.push_back(8'h00);
    for (int i = 0; i < 4; i++) begin
      ii = 2'(i);
      cmd_q.push_back({6'b101000, ii});
      cmd_q.push_back(8'h00);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a1, input logic [31:0] a2,
                      input logic [31:0] result, input int lat, input bit expect_rsp);
    int n;
    push_cmds(op, a1, a2);
    if (expect_rsp) begin
      rsp_q.push_back(result);
      lat_q.push_back(lat);
    end
    rd_model = result;
    @(posedge clk); #1;
    req_valid = 1'b1; req_opcode = op; req_arg1 = a1; req_arg2 = a2;
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 50) begin
        $display("FAIL accept_timeout: req_ready never rose");
        $fatal(1);
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #2;
      if (!active && rsp_q.size() == 0) return;
    end
    $display("FAIL rsp_timeout: response never completed");
    $fatal(1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b1; req_opcode = 3'd3;
    req_arg1 = 32'h0; req_arg2 = 32'h0; rsp_ready = 1'b1; rd_byte = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (2) @(posedge clk);

    // multiply, twice (second also exercises the perf transaction count)
    send(3'd3, 32'h05040302, 32'h00000001, 32'h44332211, 59, 1'b1);
    wait_done();
    send(3'd3, 32'h05040302, 32'h00000001, 32'h8899AABB, 59, 1'b1);
    wait_done();

    // sin_cos: LOAD2 skipped, four cycles shorter
    send(3'd0, 32'h00000701, 32'hFFFFFFFF, 32'hDDCCBBAA, 55, 1'b1);
    wait_done();

    // atan2 with 10 cycles of response backpressure and a competing request
    rsp_ready = 1'b0;
    send(3'd1, 32'h12345678, 32'h9ABCDEF0, 32'hCAFEF00D, 59, 1'b1);
    for (int n = 0; n < 200 && !rsp_valid; n++) begin
      @(posedge clk); #2;
    end
    req_valid = 1'b1; req_opcode = 3'd2; req_arg1 = 32'h1; req_arg2 = 32'h2;
    repeat (10) @(posedge clk);
    #1 rsp_ready = 1'b1; req_valid = 1'b0;
    wait_done();

    // reset in the middle of WAIT aborts silently
    send(3'd3, 32'h01010101, 32'h02020202, 32'h0BADBEEF, 59, 1'b0);
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // sqrt_mag completes normally after the abort
    send(3'd2, 32'h00070006, 32'h00000005, 32'h01020304, 59, 1'b1);
    wait_done();

    // unchecked opcode 7 still runs the full two-argument sequence
    send(3'd7, 32'hFFFFFFFF, 32'h00000000, 32'h5A5AA5A5, 59, 1'b1);
    wait_done();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
